dump_gate_drive: RTL
====================

Name: dump_gate_drive

Overview:
- Downstream stage of the dump sequencer. Consumes its dump_on/dump_off pulses and drives the two power-switch gates of the NMR antenna dump circuit: the dump (discharge) switch and the hold (clamp) switch.
- Guarantees the two gates are never on together, inserts dead time on every transition, and caps dump-on duration with a watchdog.
- Reports status and sticky fault flags to the control logic. Flags are cleared on each new measurement (state_start).

Parameters:
- DEAD_CYC, 4, dead-time length in clk_sys cycles with both gates off; legal range 1..15.
- MAX_ON_CYC, 4000, maximum clk_sys cycles gate_dump may stay high; 12-bit value, 1..4095.

Ports:
- clk_sys  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- drv_en  input  1  drive enable; 0 forces both gates off.
- state_start  input  1  measurement-start pulse; clears flags and counter.
- dump_on  input  1  request to enter dump; rising edge is significant.
- dump_off  input  1  request to leave dump; rising edge is significant.
- gate_dump  output  1  dump switch gate, registered.
- gate_hold  output  1  hold switch gate, registered.
- busy  output  1  high in any state other than HOLD and IDLE.
- err_timeout  output  1  sticky: watchdog forced dump off.
- err_conflict  output  1  sticky: request illegal in current state, or on/off edges in the same cycle.
- dump_cnt  output  8  completed dump pulses (optional feature).

Behaviour:
- Reset: one clock, clk_sys; reset is asynchronous and active-low on rst_n. During reset:
  - state = IDLE;
  - all outputs 0;
  - edge registers 0;
  - counters 0.
- Edge detect:
  - rise_on = dump_on & ~dump_on_d; rise_off = dump_off & ~dump_off_d.
  - dump_on_d and dump_off_d are registered every cycle.
  - A held-high input produces only one event.
- Outputs are registered from next-state decode:
  - gate_hold = (next == HOLD); gate_dump = (next == DUMP).
  - Gates therefore change on the same edge as the state.
- States and transitions:
  - IDLE: both gates 0. drv_en=1 -> DT_OFF.
  - DT_OFF: both 0; dead counter runs 0..DEAD_CYC-1. On expiry -> HOLD. Edges here are ignored; rise_on sets err_conflict.
  - HOLD: gate_hold=1.
    - rise_on & ~rise_off -> DT_ON, dead counter cleared.
    - rise_on & rise_off -> stay HOLD, set err_conflict.
    - rise_off alone is ignored.
  - DT_ON: both 0. Expiry after DEAD_CYC cycles -> DUMP, on-counter cleared. rise_off -> DT_OFF, dead counter restarted.
  - DUMP: gate_dump=1; on-counter increments each cycle.
    - rise_off -> DT_OFF.
    - on-counter == MAX_ON_CYC-1 -> DT_OFF and set err_timeout.
    - rise_on sets err_conflict; state unchanged.
    - If rise_off and timeout occur in the same cycle, take DT_OFF and set err_timeout.
- drv_en=0 in any state -> IDLE on the next edge; both gates go 0 on that edge. This takes priority over all events.
- Latency: with rise_on sampled at edge k in HOLD:
  - gate_hold falls at edge k;
  - gate_dump rises at edge k+DEAD_CYC.
- Dump and off paths are symmetric.
- Invariant: gate_dump & gate_hold is never 1, including through reset and drv_en toggling.
- state_start=1:
  - clears err_timeout, err_conflict and dump_cnt;
  - does not change state or gates;
  - if a flag-set event occurs in the same cycle, the set wins.
- Counter widths: dead counter 4 bits; on-counter 12 bits, saturating never needed because of the MAX_ON_CYC bound.

Optional Feature:
- Macro: DUMP_GATE_DRIVE_CNT_EN.
- Defined:
  - dump_cnt increments on every DUMP -> DT_OFF transition (normal or timeout).
  - Wraps 255 -> 0.
  - Cleared by state_start and reset.
- Undefined: dump_cnt tied to 8'd0 and no counter logic is synthesized.

Test Plan:
- Reset release with drv_en=1, DEAD_CYC=4 -> gates 0 for 4 cycles after IDLE->DT_OFF, then gate_hold=1, busy=0.
- dump_on rises at cycle 100 in HOLD -> gate_hold=0 at 100, gate_dump=1 at 104; dump_off rises at 200 -> gate_dump=0 at 200, gate_hold=1 at 204; dump_cnt=1.
- MAX_ON_CYC=16, dump_on with no dump_off -> gate_dump high exactly 16 cycles, err_timeout=1, return to HOLD; state_start pulse -> err_timeout=0.
- dump_on and dump_off rise in the same cycle in HOLD -> remain HOLD, err_conflict=1, gates unchanged.
- dump_off arrives 2 cycles into DT_ON -> never gate_dump=1, DT_OFF for 4 cycles, then HOLD.
- drv_en dropped mid-DUMP -> both gates 0 next edge, state IDLE. Throughout all tests, gate_dump & gate_hold is asserted-never (checked by assertion).

Source files
------------

// File: rtl/dump_gate_drive.sv
// dump_gate_drive: break-before-make dump/hold gate driver with watchdog; DUMP_GATE_DRIVE_CNT_EN adds a dump pulse counter
module dump_gate_drive #(
  parameter int DEAD_CYC   = 4,
  parameter int MAX_ON_CYC = 4000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       drv_en,
  input  logic       state_start,
  input  logic       dump_on,
  input  logic       dump_off,
  output logic       gate_dump,
  output logic       gate_hold,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_conflict,
  output logic [7:0] dump_cnt
);
  typedef enum logic [2:0] {IDLE, DT_OFF, HOLD, DT_ON, DUMP} state_t;
  state_t state, nxt;
  logic dump_on_d, dump_off_d, rise_on, rise_off, dead_done, on_done, to_set, cf_set, dump_end;
  logic [3:0] dead_cnt;
  logic [11:0] on_cnt;
  always_comb begin
    rise_on   = dump_on & ~dump_on_d;
    rise_off  = dump_off & ~dump_off_d;
    dead_done = dead_cnt == 4'(DEAD_CYC - 1);
    on_done   = on_cnt == 12'(MAX_ON_CYC - 1);
    nxt       = state;
    case (state)
      IDLE:    nxt = DT_OFF;
      DT_OFF:  nxt = dead_done ? HOLD : DT_OFF;
      HOLD:    nxt = (rise_on & ~rise_off) ? DT_ON : HOLD;
      DT_ON:   nxt = rise_off ? DT_OFF : dead_done ? DUMP : DT_ON;
      DUMP:    nxt = (rise_off | on_done) ? DT_OFF : DUMP;
      default: nxt = IDLE;
    endcase
    nxt      = drv_en ? nxt : IDLE;
    to_set   = drv_en & (state == DUMP) & on_done;
    cf_set   = drv_en & (state != IDLE) & rise_on & (rise_off | state == DT_OFF | state == DUMP);
    dump_end = (state == DUMP) & (nxt == DT_OFF);
  end
  // Counters restart on every state change, so each dead/on interval starts from zero.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dump_on_d    <= 1'b0;
      dump_off_d   <= 1'b0;
      dead_cnt     <= 4'd0;
      on_cnt       <= 12'd0;
      gate_dump    <= 1'b0;
      gate_hold    <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      state        <= nxt;
      dump_on_d    <= dump_on;
      dump_off_d   <= dump_off;
      dead_cnt     <= (nxt == state) ? dead_cnt + 4'd1 : 4'd0;
      on_cnt       <= (nxt == state) ? on_cnt + 12'd1 : 12'd0;
      gate_dump    <= nxt == DUMP;
      gate_hold    <= nxt == HOLD;
      busy         <= (nxt != HOLD) && (nxt != IDLE);
      err_timeout  <= to_set | (err_timeout & ~state_start);
      err_conflict <= cf_set | (err_conflict & ~state_start);
    end
  end
`ifdef DUMP_GATE_DRIVE_CNT_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) dump_cnt <= 8'd0;
    else dump_cnt <= (state_start ? 8'd0 : dump_cnt) + {7'd0, dump_end};
  end
`else
  assign dump_cnt = 8'd0;
  logic unused_dump_end;
  assign unused_dump_end = dump_end;
`endif
endmodule
